// File: rtl/cdb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cdb_arbiter_pkg : shared constants, CDB port struct and index helper. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cdb_arbiter_pkg;

  localparam int NUM_FU             = 6;
  localparam int CDB_WIDTH          = 16;
  localparam int NUM_CDB_PORTS      = 2;
  localparam int CDB_ARB_FIFO_DEPTH = 2;
  localparam int CDB_SRC_W          = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic                 v;
    logic [CDB_SRC_W-1:0] src;
    logic [CDB_WIDTH-1:0] data;
  } cdb_port_t;

  // (base + off) mod n, for base and off both already below n
  function automatic int rot_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_req_fifo.sv
// ----------------------------------------------------------------------------
// cdb_req_fifo : per-FU result FIFO with enqueue, dequeue and flush. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cdb_req_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter  int DEPTH  = CDB_ARB_FIFO_DEPTH,
  parameter  int DATA_W = CDB_WIDTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              flush_i,
  input  logic              enq_i,
  input  logic              deq_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q + PTR_W'(enq_i);
    rd_d  = rd_q + PTR_W'(deq_i);
    cnt_d = cnt_q + CNT_W'(enq_i) - CNT_W'(deq_i);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && !flush_i && enq_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter : round-robin multi-grant CDB arbiter over per-FU FIFOs.
// Define CDB_ARB_PERF_EN to add per-FU stall counters (stall_cnt_o). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = NUM_FU,
  parameter  int NUM_PORTS  = NUM_CDB_PORTS,
  parameter  int DATA_W     = CDB_WIDTH,
  parameter  int FIFO_DEPTH = CDB_ARB_FIFO_DEPTH,
  localparam int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [NUM_REQ-1:0]                req_v_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic                              flush_i,
  output logic [NUM_PORTS-1:0]              cdb_v_o,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  cdb_data_o,
  output logic [NUM_PORTS-1:0][SRC_W-1:0]   cdb_src_o
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][15:0]          stall_cnt_o
`endif
);

  logic [DATA_W-1:0] head_w  [NUM_REQ];
  logic [CNT_W-1:0]  count_w [NUM_REQ];
  logic [NUM_REQ-1:0] nonempty_w, grant_w;
  logic [SRC_W-1:0]   rr_q, rr_d;
  cdb_port_t          port_q [NUM_PORTS];
  cdb_port_t          port_d [NUM_PORTS];
  int                 n_w;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
      assign req_ready_o[i] = (count_w[i] < CNT_W'(FIFO_DEPTH));
      assign nonempty_w[i]  = (count_w[i] != '0);

      cdb_req_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
      ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .enq_i     (req_v_i[i] & req_ready_o[i]),
        .deq_i     (grant_w[i]),
        .data_i    (req_data_i[i]),
        .head_o    (head_w[i]),
        .count_o   (count_w[i])
      );
    end
  endgenerate

  // Visit FIFOs in rotated order from rr_q; the n-th hit drives port n.
  always_comb begin
    grant_w = '0;
    rr_d    = rr_q;
    n_w     = 0;
    for (int p = 0; p < NUM_PORTS; p++) port_d[p] = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == rot_idx(int'(rr_q), k, NUM_REQ) && nonempty_w[j] && n_w < NUM_PORTS) begin
          grant_w[j] = 1'b1;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (p == n_w) begin
              port_d[p].v    = 1'b1;
              port_d[p].src  = CDB_SRC_W'(j);
              port_d[p].data = CDB_WIDTH'(head_w[j]);
            end
          end
          n_w  = n_w + 1;
          rr_d = SRC_W'(rot_idx(j, 1, NUM_REQ));
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) port_q[p] <= '0;
    end else if (flush_i) begin
      for (int p = 0; p < NUM_PORTS; p++) port_q[p] <= '0;
    end else begin
      rr_q <= rr_d;
      for (int p = 0; p < NUM_PORTS; p++) port_q[p] <= port_d[p];
    end
  end

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
      assign cdb_v_o[p]    = port_q[p].v;
      assign cdb_src_o[p]  = SRC_W'(port_q[p].src);
      assign cdb_data_o[p] = DATA_W'(port_q[p].data);
    end
  endgenerate

`ifdef CDB_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_v_i[i] && !req_ready_o[i] && !flush_i && stall_q[i] != 16'hFFFF) begin
          stall_q[i] <= stall_q[i] + 16'd1;
        end
      end
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_arbiter : directed and random stimulus against a queue-based model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NR = NUM_FU;
  localparam int NP = NUM_CDB_PORTS;
  localparam int DW = CDB_WIDTH;
  localparam int D  = CDB_ARB_FIFO_DEPTH;
  localparam int SW = $clog2(NR);

  logic                       clk_i = 1'b0;
  logic                       reset_n_i = 1'b0;
  logic [NR-1:0]              req_v_i = '0;
  logic [NR-1:0][DW-1:0]      req_data_i = '0;
  logic [NR-1:0]              req_ready_o;
  logic                       flush_i = 1'b0;
  logic [NP-1:0]              cdb_v_o;
  logic [NP-1:0][DW-1:0]      cdb_data_o;
  logic [NP-1:0][SW-1:0]      cdb_src_o;
`ifdef CDB_ARB_PERF_EN
  logic [NR-1:0][15:0]        stall_cnt_o;
`endif

  cdb_arbiter dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .req_v_i     (req_v_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .flush_i     (flush_i),
    .cdb_v_o     (cdb_v_o),
    .cdb_data_o  (cdb_data_o),
    .cdb_src_o   (cdb_src_o)
`ifdef CDB_ARB_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: one FIFO queue per FU, a round-robin start index, expected outputs.
  logic [DW-1:0]         mq [NR][$];
  int                    rr = 0;
  int                    seq [NR];
  int                    stall [NR];
  logic [NP-1:0]         ev;
  logic [NP-1:0][DW-1:0] ed;
  logic [NP-1:0][SW-1:0] es;
  logic [NR-1:0]         erdy;
  logic                  use_a5 = 1'b0;
  logic                  saw_full3;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [NR-1:0] v, input logic [NR-1:0][DW-1:0] d,
                            input logic fl, input logic rn, output logic [NR-1:0] acc);
    int ng;
    int last;
    ev = '0; ed = '0; es = '0; acc = '0;
    if (!rn) begin
      for (int i = 0; i < NR; i++) begin mq[i].delete(); stall[i] = 0; end
      rr = 0;
    end else begin
      for (int i = 0; i < NR; i++)
        if (v[i] && mq[i].size() >= D && !fl && stall[i] < 65535) stall[i]++;
      if (fl) begin
        for (int i = 0; i < NR; i++) mq[i].delete();
      end else begin
        ng = 0; last = -1;
        for (int k = 0; k < NR; k++) begin
          int idx;
          idx = (rr + k) % NR;
          if (ng < NP && mq[idx].size() > 0) begin
            ev[ng] = 1'b1; ed[ng] = mq[idx][0]; es[ng] = SW'(idx);
            ng++; last = idx;
          end
        end
        for (int i = 0; i < NR; i++) acc[i] = v[i] && (mq[i].size() < D);
        for (int p = 0; p < ng; p++) void'(mq[es[p]].pop_front());
        for (int i = 0; i < NR; i++) if (acc[i]) mq[i].push_back(d[i]);
        if (ng > 0) rr = (last + 1) % NR;
      end
    end
    for (int i = 0; i < NR; i++) erdy[i] = (mq[i].size() < D);
  endtask

  task automatic cyc(input logic [NR-1:0] v, input logic fl, input logic rn);
    logic [NR-1:0] acc;
    req_v_i = v; flush_i = fl; reset_n_i = rn;
    for (int i = 0; i < NR; i++) req_data_i[i] = DW'((i << 12) | (seq[i] & 'hFFF));
    if (use_a5) req_data_i[2] = DW'(16'h00A5);
    @(posedge clk_i);
    model_edge(v, req_data_i, fl, rn, acc);
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) seq[i]++;
    chk("cdb_v", 128'(cdb_v_o), 128'(ev));
    chk("cdb_data", 128'(cdb_data_o), 128'(ed));
    chk("cdb_src", 128'(cdb_src_o), 128'(es));
    chk("req_ready", 128'(req_ready_o), 128'(erdy));
`ifdef CDB_ARB_PERF_EN
    for (int i = 0; i < NR; i++) chk("stall_cnt", 128'(stall_cnt_o[i]), 128'(stall[i]));
`endif
  endtask

  function automatic logic [NP-1:0][SW-1:0] src2(input int a, input int b);
    logic [NP-1:0][SW-1:0] r;
    r = '0; r[0] = SW'(a); r[1] = SW'(b);
    return r;
  endfunction

  initial begin
    for (int i = 0; i < NR; i++) begin seq[i] = 1; stall[i] = 0; end

    // Reset held with every FU valid
    repeat (3) cyc('1, 1'b0, 1'b0);
    chk("rst_cdb_v", 128'(cdb_v_o), 128'(0));
    cyc('0, 1'b0, 1'b1);
    chk("rst_ready", 128'(req_ready_o), 128'(6'h3F));

    // Single FU 2 carrying 0xA5: visible two edges later on port 0
    use_a5 = 1'b1;
    cyc(6'b000100, 1'b0, 1'b1);
    use_a5 = 1'b0;
    chk("single_early_v", 128'(cdb_v_o), 128'(0));
    cyc('0, 1'b0, 1'b1);
    chk("single_v0", 128'(cdb_v_o[0]), 128'(1));
    chk("single_data0", 128'(cdb_data_o[0]), 128'(16'h00A5));
    chk("single_src0", 128'(cdb_src_o[0]), 128'(2));

    // Contention from rr=0: pairs {0,1},{2,3},{4,5}, then wrap back to {0,1}
    cyc('0, 1'b0, 1'b0);
    cyc('1, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1);
    chk("cont_src01", 128'(cdb_src_o), 128'(src2(0, 1)));
    cyc('0, 1'b0, 1'b1);
    chk("cont_src23", 128'(cdb_src_o), 128'(src2(2, 3)));
    cyc('0, 1'b0, 1'b1);
    chk("cont_src45", 128'(cdb_src_o), 128'(src2(4, 5)));
    cyc('1, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1);
    chk("cont_wrap01", 128'(cdb_src_o), 128'(src2(0, 1)));

    // Back-pressure: FUs 0..3 valid every cycle, FIFO 3 must fill
    saw_full3 = 1'b0;
    repeat (10) begin
      cyc(6'b001111, 1'b0, 1'b1);
      if (!req_ready_o[3]) saw_full3 = 1'b1;
    end
    chk("bp_ready3_low", 128'(saw_full3), 128'(1));

    // Flush with a concurrent FU1 enqueue
    cyc(6'b000010, 1'b1, 1'b1);
    chk("flush_v", 128'(cdb_v_o), 128'(0));
    chk("flush_ready", 128'(req_ready_o), 128'(6'h3F));
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1);
    chk("flush_drained", 128'(cdb_v_o), 128'(0));

    // Random traffic with occasional flush and reset
    for (int t = 0; t < 600; t++) begin
      cyc(NR'($urandom), ($urandom_range(0, 24) == 0), ($urandom_range(0, 79) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
